// File: rtl/gpio_serial_cfg_loader.sv
// gpio_serial_cfg_loader
// Holds one configuration word per GPIO pad. On request, or once after
// reset, it shifts the whole array MSB first into the pad configuration
// chain: pad NUM_PADS-1 goes out first and pad 0 last, so pad 0 ends up
// nearest the chain head. It then strobes serial_load to transfer the
// chain into the pad latches.

module gpio_serial_cfg_loader #(
   parameter int                  NUM_PADS    = 19,
   parameter int                  CFG_BITS    = 13,
   parameter int                  CLK_DIV     = 2,
   parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 13'h0403,
   parameter bit                  AUTO_LOAD   = 1'b1,
   localparam int                 AW          = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                start,
   input  logic                cfg_wr_en,
   input  logic [AW-1:0]       cfg_wr_addr,
   input  logic [CFG_BITS-1:0] cfg_wr_data,
   input  logic [AW-1:0]       cfg_rd_addr,
   output logic [CFG_BITS-1:0] cfg_rd_data,
   output logic                cfg_wr_err,
   output logic                busy,
   output logic                done,
   output logic                serial_clock,
   output logic                serial_data_out,
   output logic                serial_load,
   output logic                serial_resetn
);

   localparam int TOT = NUM_PADS * CFG_BITS;
   localparam int CW  = (TOT > 1) ? $clog2(TOT) : 1;
   localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CFG_BITS-1:0] r_cfg [NUM_PADS];
   logic [TOT-1:0]      w_flat;
   logic [TOT-1:0]      r_shift;
   logic [TOT-1:0]      w_shift_adv;
   logic [CW-1:0]       r_bit_cnt;
   logic [DW-1:0]       r_div;
   logic                w_div_last;
   logic                r_auto_pend;
   logic                w_trigger;
   logic                w_addr_ok;
   logic                w_wr_ok;
   logic                w_wr_err;
   logic                r_busy;
   logic                r_done;
   logic                r_wr_err;
   logic                r_sclk;
   logic                r_sdo;
   logic                r_sload;
   logic                r_resetn;

   // Pad gi occupies slice gi of the flat image, so pad NUM_PADS-1 sits at the MSB end and leaves first
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PADS; gi++) begin : g_flat
         assign w_flat[gi*CFG_BITS +: CFG_BITS] = r_cfg[gi];
      end
   endgenerate

   assign w_shift_adv = r_shift << 1;
   assign w_div_last  = (r_div == DW'(CLK_DIV - 1));
   assign w_trigger   = start | r_auto_pend;
   assign w_wr_ok     = cfg_wr_en & (r_state == IDLE) & w_addr_ok;
   assign w_wr_err    = cfg_wr_en & ~w_wr_ok;

   // Address decode for the write range check and the combinational read port
   always_comb begin
      w_addr_ok   = 1'b0;
      cfg_rd_data = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (cfg_wr_addr == AW'(i)) w_addr_ok = 1'b1;
         if (cfg_rd_addr == AW'(i)) cfg_rd_data = r_cfg[i];
      end
   end

   // Configuration array: writes land only while idle, so a load in flight never sees a torn image
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < NUM_PADS; i++) r_cfg[i] <= DEFAULT_CFG;
      end else if (w_wr_ok) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            if (cfg_wr_addr == AW'(i)) r_cfg[i] <= cfg_wr_data;
         end
      end
   end

   // FSM state register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   // FSM next-state: every non-idle state lasts CLK_DIV cycles
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:     if (w_trigger)  w_state_next = SHIFT_LO;
         SHIFT_LO: if (w_div_last) w_state_next = SHIFT_HI;
         SHIFT_HI: if (w_div_last) w_state_next = (r_bit_cnt == '0) ? LOAD : SHIFT_LO;
         LOAD:     if (w_div_last) w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs; outputs are decoded from the next state so they align with it
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_div       <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_auto_pend <= AUTO_LOAD;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_wr_err    <= 1'b0;
         r_sclk      <= 1'b0;
         r_sdo       <= 1'b0;
         r_sload     <= 1'b0;
         r_resetn    <= 1'b0;
      end else begin
         r_resetn    <= 1'b1;
         r_auto_pend <= 1'b0;
         r_wr_err    <= w_wr_err;
         r_busy      <= (w_state_next != IDLE);
         r_done      <= (r_state == LOAD) && w_div_last;
         r_sclk      <= (w_state_next == SHIFT_HI);
         r_sload     <= (w_state_next == LOAD);

         if (r_state == IDLE || w_state_next != r_state) r_div <= '0;
         else                                             r_div <= r_div + 1'b1;

         // Data only moves on entry to SHIFT_LO, giving CLK_DIV cycles of setup before the rising edge
         if (r_state == IDLE && w_trigger) begin
            r_shift   <= w_flat;
            r_bit_cnt <= CW'(TOT - 1);
            r_sdo     <= w_flat[TOT-1];
         end else if (r_state == SHIFT_HI && w_div_last && r_bit_cnt != '0) begin
            r_shift   <= w_shift_adv;
            r_bit_cnt <= r_bit_cnt - 1'b1;
            r_sdo     <= w_shift_adv[TOT-1];
         end
      end
   end

   assign busy            = r_busy;
   assign done            = r_done;
   assign cfg_wr_err      = r_wr_err;
   assign serial_clock    = r_sclk;
   assign serial_data_out = r_sdo;
   assign serial_load     = r_sload;
   assign serial_resetn   = r_resetn;

endmodule

// File: tb/tb_gpio_serial_cfg_loader.sv
// Bench for gpio_serial_cfg_loader: a 2-pad, CLK_DIV=2 instance (A) and a
// 1-pad, CLK_DIV=1 instance (B). Pad words are kept in a plain array model;
// the serial stream is captured at every serial_clock rise and regrouped
// into pad words.

module tb_gpio_serial_cfg_loader;

   localparam int          NA    = 2;
   localparam int          DA    = 2;
   localparam int          NB    = 1;
   localparam int          DB    = 1;
   localparam int          BITS  = 13;
   localparam int          LEN_A = 2 * DA * NA * BITS + DA;
   localparam int          LEN_B = 2 * DB * NB * BITS + DB;
   localparam logic [12:0] DEF   = 13'h0403;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, wr_en_a, err_a, busy_a, done_a, sclk_a, sdo_a, sload_a, srn_a;
   logic [0:0]  wr_addr_a, rd_addr_a;
   logic [12:0] wr_data_a, rd_data_a;
   logic        start_b, wr_en_b, err_b, busy_b, done_b, sclk_b, sdo_b, sload_b, srn_b;
   logic [0:0]  wr_addr_b, rd_addr_b;
   logic [12:0] wr_data_b, rd_data_b;

   gpio_serial_cfg_loader #(.NUM_PADS(NA), .CFG_BITS(BITS), .CLK_DIV(DA),
                            .DEFAULT_CFG(DEF), .AUTO_LOAD(1'b1)) u_dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .cfg_wr_en(wr_en_a),
      .cfg_wr_addr(wr_addr_a), .cfg_wr_data(wr_data_a), .cfg_rd_addr(rd_addr_a),
      .cfg_rd_data(rd_data_a), .cfg_wr_err(err_a), .busy(busy_a), .done(done_a),
      .serial_clock(sclk_a), .serial_data_out(sdo_a), .serial_load(sload_a),
      .serial_resetn(srn_a));

   gpio_serial_cfg_loader #(.NUM_PADS(NB), .CFG_BITS(BITS), .CLK_DIV(DB),
                            .DEFAULT_CFG(DEF), .AUTO_LOAD(1'b1)) u_dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .cfg_wr_en(wr_en_b),
      .cfg_wr_addr(wr_addr_b), .cfg_wr_data(wr_data_b), .cfg_rd_addr(rd_addr_b),
      .cfg_rd_data(rd_data_b), .cfg_wr_err(err_b), .busy(busy_b), .done(done_b),
      .serial_clock(sclk_b), .serial_data_out(sdo_b), .serial_load(sload_b),
      .serial_resetn(srn_b));

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: intended pad words
   logic [12:0] m_a [NA];
   logic [12:0] m_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor A: observed sequence properties, sampled on the falling edge
   int   busy_cyc, done_cnt, load_cyc, err_cnt, rises, stab_bad, overlap;
   bit   bits_a [$];
   logic prev_sclk_a = 1'b0;
   logic sdo_rise_a  = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (busy_a)  busy_cyc++;
         if (done_a)  done_cnt++;
         if (sload_a) load_cyc++;
         if (err_a)   err_cnt++;
         if (sclk_a && sload_a) overlap++;
         if (sclk_a && !prev_sclk_a) begin
            rises++;
            bits_a.push_back(sdo_a);
            sdo_rise_a = sdo_a;
         end else if (sclk_a && sdo_a !== sdo_rise_a) begin
            stab_bad++;
         end
      end
      prev_sclk_a = sclk_a;
   end

   task automatic clr_mon();
      busy_cyc = 0; done_cnt = 0; load_cyc = 0; err_cnt = 0;
      rises = 0; stab_bad = 0; overlap = 0;
      bits_a.delete();
   endtask

   // Monitor B: also counts serial_clock toggles between consecutive busy cycles
   int          busy_b_cyc, done_b_cnt, load_b_cyc, rises_b, tog_b, overlap_b;
   logic [12:0] word_b;
   logic        prev_sclk_b = 1'b0;
   logic        prev_busy_b = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (busy_b)  busy_b_cyc++;
         if (done_b)  done_b_cnt++;
         if (sload_b) load_b_cyc++;
         if (sclk_b && sload_b) overlap_b++;
         if (busy_b && prev_busy_b && sclk_b != prev_sclk_b) tog_b++;
         if (sclk_b && !prev_sclk_b) begin
            rises_b++;
            word_b = {word_b[11:0], sdo_b};
         end
      end
      prev_sclk_b = sclk_b;
      prev_busy_b = busy_b;
   end

   task automatic clr_mon_b();
      busy_b_cyc = 0; done_b_cnt = 0; load_b_cyc = 0;
      rises_b = 0; tog_b = 0; overlap_b = 0; word_b = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},   {busy_a, busy_b},   2'b00);
      check({tag, "_done"},   {done_a, done_b},   2'b00);
      check({tag, "_err"},    {err_a, err_b},     2'b00);
      check({tag, "_sclk"},   {sclk_a, sclk_b},   2'b00);
      check({tag, "_sdo"},    {sdo_a, sdo_b},     2'b00);
      check({tag, "_sload"},  {sload_a, sload_b}, 2'b00);
      check({tag, "_resetn"}, {srn_a, srn_b},     2'b00);
   endtask

   task automatic write_a(input int pad, input logic [12:0] data);
      wr_en_a = 1'b1; wr_addr_a = 1'(pad); wr_data_a = data;
      tick();
      wr_en_a = 1'b0;
      m_a[pad] = data;
      check("wr_idle_err", err_a, 1'b0);
   endtask

   // One load on A; optional disturbing write/start at given busy cycles, optional back-to-back restart
   task automatic run_seq(input string tag, input bit pulse_start, input int wr_at,
                          input int st_at, input bit b2b);
      int          n;
      int          idx;
      int          pad;
      logic [12:0] w;
      clr_mon();
      if (pulse_start) begin
         start_a = 1'b1; tick(); start_a = 1'b0;
      end else begin
         tick();
      end
      n = 1;
      while (busy_a && n < 1000) begin
         if (n == wr_at) begin
            pad = int'($urandom_range(0, NA - 1));
            wr_en_a = 1'b1; wr_addr_a = 1'(pad); wr_data_a = ~m_a[pad];
            tick();
            wr_en_a = 1'b0;
            check({tag, "_wr_err_pulse"}, err_a, 1'b1);
         end else if (n == st_at) begin
            start_a = 1'b1; tick(); start_a = 1'b0;
         end else begin
            tick();
         end
         n++;
      end
      check({tag, "_timeout"}, (n < 1000), 1'b1);
      if (b2b) start_a = 1'b1;
      tick();
      start_a = 1'b0;
      if (b2b) check({tag, "_b2b_busy"}, busy_a, 1'b1);
      check({tag, "_len"},     busy_cyc, LEN_A);
      check({tag, "_done"},    done_cnt, 1);
      check({tag, "_load"},    load_cyc, DA);
      check({tag, "_rises"},   rises, NA * BITS);
      check({tag, "_stable"},  stab_bad, 0);
      check({tag, "_overlap"}, overlap, 0);
      check({tag, "_errcnt"},  err_cnt, (wr_at > 0) ? 1 : 0);
      idx = 0;
      for (int p = NA - 1; p >= 0; p--) begin
         w = '0;
         for (int b = 0; b < BITS; b++) begin
            w = {w[11:0], (idx < bits_a.size()) ? bits_a[idx] : 1'b0};
            idx++;
         end
         check($sformatf("%s_word%0d", tag, p), w, m_a[p]);
      end
      for (int p = 0; p < NA; p++) begin
         rd_addr_a = 1'(p);
         #1;
         check($sformatf("%s_rd%0d", tag, p), rd_data_a, m_a[p]);
      end
      $display("seq %s: busy=%0d rises=%0d pad1=%h pad0=%h", tag, busy_cyc, rises, m_a[1], m_a[0]);
   endtask

   task automatic check_b(input string tag, input logic [12:0] exp_word);
      check({tag, "_len"},     busy_b_cyc, LEN_B);
      check({tag, "_done"},    done_b_cnt, 1);
      check({tag, "_load"},    load_b_cyc, DB);
      check({tag, "_rises"},   rises_b, BITS);
      check({tag, "_toggles"}, tog_b, 2 * BITS);
      check({tag, "_overlap"}, overlap_b, 0);
      check({tag, "_word"},    word_b, exp_word);
      $display("seq %s: busy=%0d word=%h", tag, busy_b_cyc, word_b);
   endtask

   initial begin
      logic [12:0] old_b;
      logic [12:0] new_b;
      int          n;
      rst = 1'b1;
      start_a = 1'b0; wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0; rd_addr_a = '0;
      start_b = 1'b0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
      for (int p = 0; p < NA; p++) m_a[p] = DEF;
      m_b = DEF;
      repeat (3) tick();
      check_reset_outputs("reset");
      check("reset_rd_a", rd_data_a, DEF);

      // Auto-load after reset release on both instances
      clr_mon_b();
      rst = 1'b0;
      run_seq("autoload", 1'b0, -1, -1, 1'b0);
      check("resetn_high", {srn_a, srn_b}, 2'b11);
      check_b("b_autoload", DEF);

      // Write then load with fixed words, then random words
      write_a(0, 13'h1C02);
      write_a(1, 13'h0403);
      run_seq("wr_load", 1'b1, -1, -1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         write_a(0, 13'($urandom));
         write_a(1, 13'($urandom));
         run_seq($sformatf("rand%0d", k), 1'b1, -1, -1, 1'b0);
      end

      // Disturbances during a load, and a back-to-back restart on done
      run_seq("wr_busy", 1'b1, 10, -1, 1'b0);
      run_seq("st_busy", 1'b1, -1, 50, 1'b0);
      run_seq("b2b_first", 1'b1, -1, -1, 1'b1);
      run_seq("b2b_second", 1'b0, -1, -1, 1'b0);

      // B: out-of-range write is rejected with a one-cycle error pulse
      wr_en_b = 1'b1; wr_addr_b = 1'b1; wr_data_b = ~m_b;
      tick();
      wr_en_b = 1'b0;
      check("b_oor_err", err_b, 1'b1);
      check("b_oor_rd", rd_data_b, m_b);
      tick();
      check("b_oor_err_clear", err_b, 1'b0);

      // B: start together with a write shifts the old word, the write still lands
      old_b = m_b;
      new_b = 13'($urandom) ^ 13'h1555;
      if (new_b == old_b) new_b = ~old_b;
      clr_mon_b();
      start_b = 1'b1; wr_en_b = 1'b1; wr_addr_b = 1'b0; wr_data_b = new_b;
      tick();
      start_b = 1'b0; wr_en_b = 1'b0;
      m_b = new_b;
      n = 1;
      while (busy_b && n < 200) begin
         tick();
         n++;
      end
      check("b_start_wr_timeout", (n < 200), 1'b1);
      tick();
      check_b("b_start_wr", old_b);
      check("b_start_wr_rd", rd_data_b, m_b);

      // Reset in the middle of an A shift: outputs and arrays return to defaults
      write_a(0, 13'h1ABC);
      clr_mon();
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (39) tick();
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      for (int p = 0; p < NA; p++) m_a[p] = DEF;
      m_b = DEF;
      rd_addr_a = 1'b0;
      #1;
      check("rst_mid_rd_a", rd_data_a, DEF);
      check("rst_mid_rd_b", rd_data_b, DEF);
      repeat (2) tick();
      clr_mon_b();
      rst = 1'b0;
      run_seq("post_rst", 1'b0, -1, -1, 1'b0);
      check_b("b_post_rst", DEF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gpio_serial_cfg_loader.md
# gpio_serial_cfg_loader

Sequencer that holds the configuration word for every bidirectional GPIO pad wrapper and shifts it, MSB first, into the per-pad serial configuration chain. The chain then drives each wrapper's drive mode, input disable and output enable. It sits in housekeeping, between the management bus register file and the pad ring. It generates the chain's serial clock, data and load strobe from the system clock, and runs one complete load per request, plus one automatic load after reset.

## Interface
- NUM_PADS, 19, number of pads on the chain (≥1)
- CFG_BITS, 13, configuration bits per pad; dm[2:0] occupies bits [12:10], inp_dis bit 3, out_en_n bit 1
- CLK_DIV, 2, serial_clock half-period in wb_clk_i cycles (≥1)
- DEFAULT_CFG, 13'h0403, reset value of every pad word (dm=001, out_en_n=1, mgmt_ena=1)
- AUTO_LOAD, 1, when 1 a load sequence starts automatically after reset release
- wb_clk_i  in  1  system clock; all logic rising-edge
- wb_rst_i  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to load the whole chain
- cfg_wr_en  in  1  write strobe for the config array
- cfg_wr_addr  in  $clog2(NUM_PADS)  pad index to write
- cfg_wr_data  in  CFG_BITS  word to write
- cfg_rd_addr  in  $clog2(NUM_PADS)  pad index to read
- cfg_rd_data  out  CFG_BITS  combinational read of the array
- cfg_wr_err  out  1  one-cycle pulse: write rejected
- busy  out  1  load sequence in progress
- done  out  1  one-cycle pulse on sequence completion
- serial_clock  out  1  chain shift clock
- serial_data_out  out  1  chain data; stable while serial_clock high
- serial_load  out  1  chain transfer strobe, shift register to pad latches
- serial_resetn  out  1  chain reset, active-low

## Operation
- Config array: NUM_PADS × CFG_BITS registers, all DEFAULT_CFG on reset.
  - cfg_wr_en while idle writes the word on the next edge.
  - cfg_wr_en while busy is ignored, and cfg_wr_err pulses on the following cycle.
  - An out-of-range address is ignored and also pulses cfg_wr_err.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD.
- IDLE: on start=1 (or the AUTO_LOAD trigger), capture the array into the shift buffer, set bit counter = NUM_PADS*CFG_BITS-1, and go to SHIFT_LO.
  - start while not IDLE is ignored.
  - A start coinciding with a cfg_wr_en in IDLE uses the pre-write contents; the write still lands.
- Shift order: pad NUM_PADS-1 first, pad 0 last; within a pad, bit CFG_BITS-1 first. This leaves pad 0's word nearest the chain head.
- SHIFT_LO: serial_clock=0, serial_data_out=current bit, for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: serial_clock=1 for CLK_DIV cycles.
  - If counter≠0: decrement, advance bit, go to SHIFT_LO.
  - Else: go to LOAD.
- LOAD: serial_clock=0, serial_load=1 for CLK_DIV cycles, then go to IDLE and pulse done.
- serial_resetn: 0 during reset; 1 from the first wb_clk_i edge after release.
- AUTO_LOAD=1: the first edge after reset release acts as start.

## Timing
- Reset values: busy=0, done=0, cfg_wr_err=0, serial_clock=0, serial_data_out=0, serial_load=0, serial_resetn=0, FSM=IDLE.
- busy rises on the edge that samples start.
- busy stays high for exactly 2*CLK_DIV*NUM_PADS*CFG_BITS + CLK_DIV cycles.
- done is high for the single cycle in which busy first reads 0 again.
- serial_data_out changes only on the edge entering SHIFT_LO, so it has CLK_DIV cycles of setup to serial_clock rising.
- serial_load is never high while serial_clock is high.
- All serial outputs are registered; there are no combinational paths from inputs.
- Reset asserted mid-sequence:
  - All outputs take their reset values immediately.
  - The array returns to DEFAULT_CFG.
  - The chain contents are undefined until the next load; AUTO_LOAD covers this.
- A new start in the cycle done pulses is accepted, giving back-to-back sequences with one idle cycle.

## Test plan
- **Auto-load.** Config NUM_PADS=2, CFG_BITS=13, CLK_DIV=2, AUTO_LOAD=1. Release reset.
  - busy high for 106 cycles.
  - 26 serial_clock rising edges; sampled data = 0x0403 MSB-first twice.
  - serial_load high 2 cycles; done pulses once.
- **Write then load.** Write pad0=13'h1C02 and pad1=13'h0403, then pulse start.
  - First 13 sampled bits = 0x0403, next 13 = 0x1C02.
  - cfg_rd_data(0) = 13'h1C02.
- **Write during busy.** Pulse cfg_wr_en at cycle 10 of a sequence.
  - cfg_wr_err pulses one cycle later.
  - Array unchanged; shifted data unchanged.
- **Start while busy.** Pulse start at cycle 50.
  - Sequence length still 106.
  - Only one done pulse.
- **Reset mid-shift.** Assert wb_rst_i at cycle 40.
  - Outputs reset immediately.
  - After release, a fresh 106-cycle auto-load of DEFAULT_CFG runs.
- **Divider minimum.** CLK_DIV=1, NUM_PADS=1.
  - busy = 27 cycles.
  - serial_clock toggles every cycle.
  - serial_data_out stable across each rising edge.
